// File: rtl/ram_bank_seq_pkg.sv
// Shared types and constants for the RAM bank write sequencer and its bench.
package ram_bank_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int          NUM_BANKS    = 8;
    localparam int          DEPTH        = 16;
    localparam int          WORD_COUNT_W = 8;
    localparam int          SEL_W        = 4;
    localparam logic [3:0]  NO_BANK      = 4'd8;

endpackage

// File: rtl/bank_addr_counter.sv
// Word/bank pointer pair: the address walks 0..DEPTH-1 and then carries into the bank index.
module bank_addr_counter #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 8,
    parameter int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] addr_ptr,
    output logic [BANK_W-1:0]     bank_ptr,
    output logic                  last_word
);

    logic addr_wrap;

    assign addr_wrap = &addr_ptr;
    assign last_word = addr_wrap && (bank_ptr == BANK_W'(NUM_BANKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_ptr <= '0;
            bank_ptr <= '0;
        end else if (clr) begin
            addr_ptr <= '0;
            bank_ptr <= '0;
        end else if (inc) begin
            addr_ptr <= addr_ptr + ADDR_WIDTH'(1);
            // Carry into the next bank on the same beat, so bank boundaries cost no bubble.
            if (last_word) begin
                bank_ptr <= '0;
            end else if (addr_wrap) begin
                bank_ptr <= bank_ptr + BANK_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_bank_write_sequencer.sv
// Fills NUM_BANKS RAM banks in order from a valid/ready stream, driving a registered
// bank selector, address, data and write strobe for the downstream enable decoder.
module ram_bank_write_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [3:0]            Selector,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic [7:0]            word_count,
    output logic                  all_full,
    output logic                  done
);
    import ram_bank_seq_pkg::*;

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    state_t                state;
    state_t                state_nxt;
    logic                  accept;
    logic                  pass_init;
    logic                  ptr_clr;
    logic [ADDR_WIDTH-1:0] addr_ptr;
    logic [BANK_W-1:0]     bank_ptr;
    logic                  last_word;

    assign in_ready  = (state == FILL) && !clear;
    assign accept    = in_valid && in_ready;
    assign pass_init = (state == IDLE) && start && !clear;
    assign ptr_clr   = clear || pass_init;
    assign all_full  = (state == FULL);

    bank_addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_BANKS  (NUM_BANKS),
        .BANK_W     (BANK_W)
    ) u_bank_addr_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (accept),
        .clr       (ptr_clr),
        .addr_ptr  (addr_ptr),
        .bank_ptr  (bank_ptr),
        .last_word (last_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear has priority over start and over the final beat.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FILL;
                FILL:    if (accept && last_word) state_nxt = FULL;
                default: state_nxt = state;
            endcase
        end
    end

    // Output stage: one cycle after the accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Selector   <= NO_BANK;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            wr_en    <= accept;
            done     <= accept && last_word;
            Selector <= accept ? 4'(bank_ptr) : NO_BANK;
            if (accept) begin
                wr_addr <= addr_ptr;
                wr_data <= in_data;
            end
            if (ptr_clr) begin
                word_count <= '0;
            end else if (accept) begin
                word_count <= word_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_bank_write_sequencer.sv
// Directed bench for ram_bank_write_sequencer: reset, single beat, bank carry, full pass, gaps, clear/reset abort.
module tb_ram_bank_write_sequencer;
    import ram_bank_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] Selector;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [7:0] word_count;
    logic       all_full;
    logic       done;

    int checks = 0;
    int errors = 0;
    int widx   = 0;

    ram_bank_write_sequencer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .NUM_BANKS  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Selector   (Selector),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .word_count (word_count),
        .all_full   (all_full),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        widx = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (Selector !== 4'd8 || wr_en !== 1'b0 || in_ready !== 1'b0 || word_count !== 8'd0 || all_full !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: Selector=%0d wr_en=%b in_ready=%b count=%0d all_full=%b done=%b (want 8 0 0 0 0 0)",
                     Selector, wr_en, in_ready, word_count, all_full, done);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (Selector !== 4'd8 || wr_en !== 1'b0 || in_ready !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL after_release: Selector=%0d wr_en=%b in_ready=%b addr=%0d data=%h", Selector, wr_en, in_ready, wr_addr, wr_data);
        end
    endtask

    task automatic test_single_beat();
        do_start();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || Selector !== 4'd0 || wr_addr !== 4'd0 || wr_data !== 8'hA5 || word_count !== 8'd1) begin
            errors++;
            $display("FAIL single_write: wr_en=%b Selector=%0d addr=%0d data=%h count=%0d want 1 0 0 a5 1",
                     wr_en, Selector, wr_addr, wr_data, word_count);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || Selector !== 4'd8 || wr_addr !== 4'd0 || wr_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle: wr_en=%b Selector=%0d addr=%0d data=%h want 0 8 0 a5", wr_en, Selector, wr_addr, wr_data);
        end
        do_clear();
    endtask

    // Streams n accepted beats; with gaps=1 in_valid is high only every other cycle.
    task automatic test_stream(input int n, input bit gaps);
        int  got = 0;
        int  cyc = 0;
        bit  v;
        logic [7:0] d;
        while (got < n && cyc < 4 * n + 10) begin
            v = gaps ? (cyc % 2 == 0) : 1'b1;
            d = 8'((widx * 7 + 3) & 8'hFF);
            in_valid = v;
            in_data  = d;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready: beat %0d in_ready=%b want 1", widx, in_ready);
            end
            tick();
            if (v) begin
                checks++;
                if (wr_en !== 1'b1 || Selector !== 4'(widx / 16) || wr_addr !== 4'(widx % 16) || wr_data !== d
                    || word_count !== 8'(widx + 1) || done !== (widx == 127)) begin
                    errors++;
                    $display("FAIL stream_write: beat %0d wr_en=%b sel=%0d addr=%0d data=%h count=%0d done=%b want 1 %0d %0d %h %0d %b",
                             widx, wr_en, Selector, wr_addr, wr_data, word_count, done,
                             widx / 16, widx % 16, d, widx + 1, widx == 127);
                end
                widx++;
                got++;
            end else begin
                checks++;
                if (wr_en !== 1'b0 || Selector !== 4'd8 || word_count !== 8'(widx)) begin
                    errors++;
                    $display("FAIL stream_gap: wr_en=%b sel=%0d count=%0d want 0 8 %0d", wr_en, Selector, word_count, widx);
                end
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d want %0d", got, n);
        end
    endtask

    task automatic test_bank_carry();
        do_start();
        test_stream(17, 1'b0);
        checks++;
        if (word_count !== 8'd17 || Selector !== 4'd1 || wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL bank_carry: count=%0d sel=%0d addr=%0d want 17 1 0", word_count, Selector, wr_addr);
        end
        do_clear();
    endtask

    task automatic test_full_pass();
        do_start();
        test_stream(128, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        checks++;
        if (in_ready !== 1'b0 || all_full !== 1'b1) begin
            errors++;
            $display("FAIL full_ready: in_ready=%b all_full=%b want 0 1", in_ready, all_full);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || Selector !== 4'd8 || done !== 1'b0 || all_full !== 1'b1 || word_count !== 8'd128 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: wr_en=%b sel=%0d done=%b all_full=%b count=%0d in_ready=%b want 0 8 0 1 128 0",
                     wr_en, Selector, done, all_full, word_count, in_ready);
        end
        do_clear();
        checks++;
        if (all_full !== 1'b0 || word_count !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_clear: all_full=%b count=%0d in_ready=%b want 0 0 0", all_full, word_count, in_ready);
        end
    endtask

    task automatic test_gaps_and_clear();
        do_start();
        test_stream(40, 1'b1);
        clear    = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: in_ready=%b want 0", in_ready);
        end
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || Selector !== 4'd8 || word_count !== 8'd0 || all_full !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: wr_en=%b sel=%0d count=%0d all_full=%b in_ready=%b want 0 8 0 0 0",
                     wr_en, Selector, word_count, all_full, in_ready);
        end
        // start together with clear must leave the sequencer idle
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_clear: in_ready=%b want 0", in_ready);
        end
        do_start();
        test_stream(1, 1'b0);
    endtask

    task automatic test_reset_mid_pass();
        do_clear();
        do_start();
        test_stream(40, 1'b0);
        in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Selector !== 4'd8 || wr_en !== 1'b0 || word_count !== 8'd0 || in_ready !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: sel=%0d wr_en=%b count=%0d in_ready=%b addr=%0d data=%h",
                     Selector, wr_en, word_count, in_ready, wr_addr, wr_data);
        end
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || Selector !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: wr_en=%b sel=%0d in_ready=%b want 0 8 0", wr_en, Selector, in_ready);
        end
        do_start();
        test_stream(1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_bank_carry();
        test_full_pass();
        test_gaps_and_clear();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
